// File: rtl/century_calendar.sv
// Century clock core: tick prescaler, sec..year calendar (2000-2099), validated load; Feb 29 in years with year[1:0]==0 only under `CENTURY_CAL_LEAP_EN`.
// Latency: fields and pulses update at the tick/load edge. No backpressure: tick and load are accepted every cycle, and load beats tick.
module century_calendar #(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [5:0] set_sec,
  input  logic [5:0] set_min,
  input  logic [4:0] set_hour,
  input  logic [4:0] set_day,
  input  logic [3:0] set_mon,
  input  logic [6:0] set_year,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [4:0] day,
  output logic [3:0] mon,
  output logic [6:0] year,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       day_tick,
  output logic       year_wrap,
  output logic       load_err
);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

  logic [SUB_W-1:0] sub;
  logic             cur_leap, set_leap;
  logic             sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap, yr_wrap;
  logic             sec_adv, load_ok;

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                    return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

`ifdef CENTURY_CAL_LEAP_EN
  assign cur_leap = (year[1:0] == 2'b00);
  assign set_leap = (set_year[1:0] == 2'b00);
`else
  assign cur_leap = 1'b0;
  assign set_leap = 1'b0;
`endif

  // Each wrap term already includes every lower wrap, so the cascade is one level of AND per field.
  always_comb begin
    sec_adv   = tick && !load && (sub == SUB_LAST);
    sec_wrap  = (sec == 6'd59);
    min_wrap  = sec_wrap && (min == 6'd59);
    hour_wrap = min_wrap && (hour == 5'd23);
    day_wrap  = hour_wrap && (day == days_in_month(mon, cur_leap));
    mon_wrap  = day_wrap && (mon == 4'd12);
    yr_wrap   = mon_wrap && (year == 7'd99);
    load_ok   = (set_sec <= 6'd59) && (set_min <= 6'd59) && (set_hour <= 5'd23) &&
                (set_mon >= 4'd1) && (set_mon <= 4'd12) && (set_year <= 7'd99) &&
                (set_day >= 5'd1) && (set_day <= days_in_month(set_mon, set_leap));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub       <= '0;
      sec       <= 6'd0;
      min       <= 6'd0;
      hour      <= 5'd0;
      day       <= 5'd1;
      mon       <= 4'd1;
      year      <= 7'd0;
      sec_tick  <= 1'b0;
      min_tick  <= 1'b0;
      day_tick  <= 1'b0;
      year_wrap <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_tick  <= 1'b0;
      min_tick  <= 1'b0;
      day_tick  <= 1'b0;
      year_wrap <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        // A rejected load still swallows a coincident tick.
        if (load_ok) begin
          sub  <= '0;
          sec  <= set_sec;
          min  <= set_min;
          hour <= set_hour;
          day  <= set_day;
          mon  <= set_mon;
          year <= set_year;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick) begin
        sub <= (sub == SUB_LAST) ? '0 : sub + 1'b1;
      end

      if (sec_adv) begin
        sec_tick  <= 1'b1;
        min_tick  <= sec_wrap;
        day_tick  <= hour_wrap;
        year_wrap <= yr_wrap;
        sec       <= sec_wrap ? 6'd0 : sec + 6'd1;
        if (sec_wrap)  min  <= min_wrap  ? 6'd0 : min + 6'd1;
        if (min_wrap)  hour <= hour_wrap ? 5'd0 : hour + 5'd1;
        if (hour_wrap) day  <= day_wrap  ? 5'd1 : day + 5'd1;
        if (day_wrap)  mon  <= mon_wrap  ? 4'd1 : mon + 4'd1;
        if (mon_wrap)  year <= yr_wrap   ? 7'd0 : year + 7'd1;
      end
    end
  end

endmodule

// File: doc/century_calendar.md
# century_calendar

Timekeeping core of the century clock. Consumes the one-cycle clock-enable pulse from the clock divider stage, prescales it to seconds, and maintains a registered second/minute/hour/day/month/year calendar spanning 2000-01-01 00:00:00 to 2099-12-31 23:59:59. It supports a validated synchronous time/date load and emits carry pulses for downstream display and alarm logic.

## Interface

- TICKS_PER_SEC, 10: number of `tick` pulses per second. Legal range is 1..1023.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle clock-enable from the divider stage. It is never high for two consecutive cycles.
- load  in  1  one-cycle strobe that samples all `set_*` inputs.
- set_sec  in  6  seconds value to load, 0..59.
- set_min  in  6  minutes value to load, 0..59.
- set_hour  in  5  hours value to load, 0..23.
- set_day  in  5  day-of-month value to load, 1..days_in_month.
- set_mon  in  4  month value to load, 1..12.
- set_year  in  7  year offset from 2000, 0..99.
- sec, min, hour, day, mon, year  out  6/6/5/5/4/7  current time, binary, registered.
- sec_tick, min_tick, day_tick  out  1  one-cycle pulses on a second increment, a minute rollover, and a day rollover.
- year_wrap  out  1  one-cycle pulse on the century rollover.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation

- Reset values:
  - Calendar outputs: sec=0, min=0, hour=0, day=1, mon=1, year=0.
  - All pulse outputs: 0.
  - Subsecond counter: 0.
- Subsecond counter `sub` has width clog2(TICKS_PER_SEC), minimum 1 bit.
  - On `tick`, if `sub == TICKS_PER_SEC-1`: clear `sub` and advance one second.
  - Otherwise, on `tick`: increment `sub`.
- Second advance is a cascade. Each field rolls over and carries into the next:
  - sec 59→0 carries into min.
  - min 59→0 carries into hour.
  - hour 23→0 carries into day.
  - day == days_in_month → 1 carries into mon.
  - mon 12→1 carries into year.
  - year 99→0 raises `year_wrap`.
- `days_in_month(mon, year)`:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - Feb is 28, or 29 per the Configuration section.
- Pulse outputs:
  - `sec_tick` fires on every second advance.
  - `min_tick` fires when sec wraps.
  - `day_tick` fires when hour wraps.
  - `year_wrap` fires when year wraps.
  - All pulses are asserted in the same cycle the fields update.
- Load handling:
  - A load is valid when every field is within its range and `set_day <= days_in_month(set_mon, set_year)`.
  - Valid load: all fields take the `set_*` values and `sub` clears to 0.
  - Invalid load: no register changes; `load_err` pulses.
- Simultaneous `load` and `tick`: load takes priority and the tick is discarded. This applies even when the load is invalid.
- The day check is based on the loaded month and year, never the current ones.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronous). The first tick after reset release counts toward `sub`.

## Timing

- A `tick` sampled at rising edge N updates the fields and pulses at edge N, so they are visible in cycle N+1. There are no extra pipeline stages.
- A `load` sampled at edge N updates the fields or `load_err` at edge N.
- Pulses last exactly one cycle. Their spacing is never less than TICKS_PER_SEC tick periods.
- The full carry cascade, including `year_wrap`, resolves in one cycle. All fields change atomically.
- Timing-critical path: `days_in_month` compare → day/mon/year update. This path must close at 50 MHz.

## Configuration

- `CENTURY_CAL_LEAP_EN` defined: Feb has 29 days when `year[1:0] == 0`. Every year divisible by 4 in 2000–2099 is a leap year, and load validation uses the same rule.
- `CENTURY_CAL_LEAP_EN` undefined: Feb always has 28 days. A load with day=29, mon=2 is rejected with `load_err`.

## Test plan

- Reset, then 10 ticks with TICKS_PER_SEC=10: sec goes 0→1 after the 10th tick, with a single `sec_tick`. Nothing changes after 9 ticks.
- Load 23:59:59 2023-12-31, then advance one second: result is 00:00:00 2024-01-01, with `min_tick` and `day_tick` high in the same cycle and `year_wrap` low.
- Load 23:59:59 2099-12-31, then advance one second: result is 2000-01-01 00:00:00 with `year_wrap` pulsed.
- Leap handling, starting from 2024-02-28 23:59:59 and advancing one second:
  - With `CENTURY_CAL_LEAP_EN`: result is 2024-02-29, and a load of 2023-02-29 gives `load_err` with no state change.
  - Without it: result is 2024-03-01.
- Invalid loads each pulse `load_err` and leave all outputs unchanged: sec=60, hour=24, mon=0, mon=13, day=31 with mon=4.
- `load` and `tick` in the same cycle with `sub == 9`: the loaded values appear, `sub` is 0, there is no `sec_tick`, and the next second needs 10 more ticks.
